// File: rtl/knn_sp_pkg.sv
// Shared types and helpers for the banked local search-space scratchpad.
// The byte-merge helper works on a fixed maximum width; callers cast in and out.
package knn_sp_pkg;

  typedef enum logic {
    SP_CLEAR = 1'b0,
    SP_READY = 1'b1
  } sp_state_e;

  // Widest word the shared merge helper supports.
  localparam int SP_MAX_DATA_WIDTH = 2048;
  localparam int SP_MAX_BE_WIDTH   = SP_MAX_DATA_WIDTH / 8;

  function automatic int sp_bank_bits(input int num_banks);
    int bits = 0;
    while ((1 << bits) < num_banks) bits++;
    return bits;
  endfunction

  function automatic int sp_row_bits(input int addr_width, input int num_banks);
    return addr_width - sp_bank_bits(num_banks);
  endfunction

  function automatic logic [SP_MAX_DATA_WIDTH-1:0] sp_byte_merge(
    input logic [SP_MAX_DATA_WIDTH-1:0] old_word,
    input logic [SP_MAX_DATA_WIDTH-1:0] new_word,
    input logic [SP_MAX_BE_WIDTH-1:0]   be
  );
    logic [SP_MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < SP_MAX_BE_WIDTH; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/knn_sp_uram_bank.sv
// One simple-dual-port, byte-enabled URAM bank with a registered, enable-held
// read output. Read and write to the same row in one cycle return the old word.
module knn_sp_uram_bank
  import knn_sp_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ROWS       = 1024,
  parameter int ROW_W      = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ROW_W-1:0]        wr_row,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ROW_W-1:0]        rd_row,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  // NOTE: memory arrays carry no reset; contents are zeroed by the clear sweep.
  (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [ROWS];

  // NOTE: non-blocking assignments make the read below see the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= DATA_WIDTH'(sp_byte_merge(SP_MAX_DATA_WIDTH'(mem[wr_row]),
                                               SP_MAX_DATA_WIDTH'(wr_data),
                                               SP_MAX_BE_WIDTH'(wr_be)));
    end
    if (rd_en) rd_data <= mem[rd_row];
  end

endmodule

// File: rtl/knn_local_sp_banked_uram.sv
// Banked 1R1W URAM scratchpad with post-reset clear sweep and pipelined reads.
// Optional macro KNN_SP_RDW_FWD_EN forwards same-cycle same-address writes to the read.
module knn_local_sp_banked_uram
  import knn_sp_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int DEPTH        = 2048,
  parameter int ADDR_WIDTH   = 11,
  parameter int NUM_BANKS    = 2,
  parameter int READ_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    init_done,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int BANK_BITS = sp_bank_bits(NUM_BANKS);
  localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = sp_row_bits(ADDR_WIDTH, NUM_BANKS);
  localparam int ROWS      = DEPTH / NUM_BANKS;
  localparam int BE_W      = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANKS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);

  // ---------------- clear FSM ----------------
  sp_state_e        state, state_next;
  logic [ROW_W-1:0] clear_row, clear_row_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SP_CLEAR;
      clear_row <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      clear_row <= clear_row_next;
      init_done <= (state == SP_READY);
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    state_next     = state;
    clear_row_next = clear_row;
    case (state)
      SP_CLEAR: begin
        clear_row_next = clear_row + ROW_W'(1);
        if (clear_row == LAST_ROW) state_next = SP_READY;
      end
      SP_READY: state_next = SP_READY;
      default:  state_next = SP_CLEAR;
    endcase
  end

  // ---------------- address decode ----------------
  logic             wr_oob, rd_oob, wr_fire, rd_fire;
  logic [SEL_W-1:0] wr_bank, rd_bank;
  logic [ROW_W-1:0] wr_row, rd_row;

  assign wr_oob  = ({1'b0, wr_addr} >= DEPTH_L);
  assign rd_oob  = ({1'b0, rd_addr} >= DEPTH_L);
  assign wr_fire = (state == SP_READY) && wr_en && !wr_oob;
  assign rd_fire = (state == SP_READY) && rd_en;
  assign wr_bank = SEL_W'(wr_addr & BANK_MASK);
  assign rd_bank = SEL_W'(rd_addr & BANK_MASK);
  assign wr_row  = ROW_W'(wr_addr >> BANK_BITS);
  assign rd_row  = ROW_W'(rd_addr >> BANK_BITS);

  // ---------------- banks ----------------
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  bank_we, bank_re;
    logic [ROW_W-1:0]      bank_wr_row;
    logic [BE_W-1:0]       bank_be;
    logic [DATA_WIDTH-1:0] bank_wd;

    // The sweep owns every bank's write port until the FSM reaches READY.
    assign bank_we     = (state == SP_CLEAR) || (wr_fire && (wr_bank == SEL_W'(b)));
    assign bank_wr_row = (state == SP_CLEAR) ? clear_row : wr_row;
    assign bank_be     = (state == SP_CLEAR) ? '1 : wr_be;
    assign bank_wd     = (state == SP_CLEAR) ? '0 : wr_data;
    assign bank_re     = rd_fire && !rd_oob && (rd_bank == SEL_W'(b));

    knn_sp_uram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROWS       (ROWS),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we),
      .wr_row  (bank_wr_row),
      .wr_be   (bank_be),
      .wr_data (bank_wd),
      .rd_en   (bank_re),
      .rd_row  (rd_row),
      .rd_data (bank_q[b])
    );
  end

  // ---------------- first read stage: select, blank, optional forward ----------------
  logic                  s1_valid, s1_blank;
  logic [SEL_W-1:0]      s1_sel;
  logic [DATA_WIDTH-1:0] s1_data;

  // s1_blank resets high so rd_data reads zero until the first real beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_blank <= 1'b1;
      s1_sel   <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_blank <= rd_oob;
        s1_sel   <= rd_bank;
      end
    end
  end

`ifdef KNN_SP_RDW_FWD_EN
  logic                  fwd_hit;
  logic [BE_W-1:0]       fwd_be;
  logic [DATA_WIDTH-1:0] fwd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit <= 1'b0;
    end else if (rd_fire) begin
      fwd_hit  <= wr_fire && (wr_addr == rd_addr);
      fwd_be   <= wr_be;
      fwd_data <= wr_data;
    end
  end

  assign s1_data = s1_blank ? '0 :
                   fwd_hit  ? DATA_WIDTH'(sp_byte_merge(SP_MAX_DATA_WIDTH'(bank_q[s1_sel]),
                                                        SP_MAX_DATA_WIDTH'(fwd_data),
                                                        SP_MAX_BE_WIDTH'(fwd_be)))
                            : bank_q[s1_sel];
`else
  assign s1_data = s1_blank ? '0 : bank_q[s1_sel];
`endif

  // ---------------- remaining latency stages ----------------
  if (READ_LATENCY == 1) begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end else begin : g_latn
    logic [READ_LATENCY-2:0] v_q;
    logic [DATA_WIDTH-1:0]   d_q [READ_LATENCY-1];

    // Data stages load only behind a valid beat, so rd_data holds between beats.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
        for (int k = 0; k < READ_LATENCY - 1; k++) d_q[k] <= '0;
      end else begin
        v_q[0] <= s1_valid;
        if (s1_valid) d_q[0] <= s1_data;
        for (int k = 1; k < READ_LATENCY - 1; k++) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) d_q[k] <= d_q[k-1];
        end
      end
    end

    assign rd_valid = v_q[READ_LATENCY-2];
    assign rd_data  = d_q[READ_LATENCY-2];
  end

endmodule

// File: tb/tb_knn_local_sp_banked_uram.sv
// Self-checking bench for knn_local_sp_banked_uram: directed vector table,
// back-to-back reads, randomized traffic against an array model, and reset sweeps.
module tb_knn_local_sp_banked_uram;

  localparam int DW    = 256;
  localparam int AW    = 11;
  localparam int BEW   = DW / 8;
  localparam int DEPTH = 2048;
  localparam int NB    = 2;
  localparam int LAT   = 3;
  localparam int CLEAR_CYCLES = DEPTH / NB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init_done;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BEW-1:0] wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  always #5 clk = ~clk;

  knn_local_sp_banked_uram #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (AW),
    .NUM_BANKS    (NB),
    .READ_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [BEW-1:0] be;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  beat_t         expq[$];
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] model_mem [DEPTH];
  vec_t          vecs [12];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < BEW; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic vec_t mkv(input logic we, input int wa, input logic [BEW-1:0] be,
                               input logic [DW-1:0] wd, input logic re, input int ra,
                               input logic [DW-1:0] exp);
    vec_t v;
    v.we = we; v.wa = AW'(wa); v.be = be; v.wd = wd;
    v.re = re; v.ra = AW'(ra); v.exp = exp;
    return v;
  endfunction

  // Each cycle: either a read beat is due now, or rd_valid is low and rd_data holds.
  task automatic check_outputs();
    if (expq.size() > 0 && expq[0].due == cyc) begin
      check("rd_valid beat", DW'(rd_valid), DW'(1));
      check("rd_data beat", rd_data, expq[0].data);
      last_data = expq[0].data;
      void'(expq.pop_front());
    end else begin
      check("rd_valid idle", DW'(rd_valid), DW'(0));
      check("rd_data hold", rd_data, last_data);
    end
  endtask

  task automatic cycle_op(input logic we, input logic [AW-1:0] wa, input logic [BEW-1:0] be,
                          input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                          input bit use_exp, input logic [DW-1:0] exp);
    logic [DW-1:0] pred;
    beat_t b;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (re) begin
      pred = (int'(ra) < DEPTH) ? model_mem[int'(ra)] : '0;
`ifdef KNN_SP_RDW_FWD_EN
      if (we && wa == ra && int'(wa) < DEPTH) pred = merge(pred, wd, be);
`endif
      b.due  = cyc + LAT;
      b.data = use_exp ? exp : pred;
      expq.push_back(b);
    end
    if (we && int'(wa) < DEPTH) model_mem[int'(wa)] = merge(model_mem[int'(wa)], wd, be);
    @(posedge clk);
    #1;
    cyc++;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_op(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Pulse reset for one edge (with traffic applied), then time the clear sweep.
  task automatic do_reset();
    int n_low;
    int n_bad;
    reset = 1'b1;
    rd_en = 1'b1; rd_addr = AW'($urandom_range(0, 7));
    wr_en = 1'b1; wr_addr = '0; wr_be = '1; wr_data = rand_word();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    expq.delete();
    last_data = '0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    check("reset rd_valid", DW'(rd_valid), DW'(0));
    check("reset rd_data", rd_data, '0);
    check("reset init_done", DW'(init_done), DW'(0));
    n_low = 0;
    n_bad = 0;
    for (int i = 0; i < CLEAR_CYCLES + 80; i++) begin
      if (i < CLEAR_CYCLES - 24) begin
        wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom()); wr_be = $urandom();
        wr_data = rand_word();
        rd_en = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom());
      end else begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rd_valid !== 1'b0 || rd_data !== '0) n_bad++;
      if (init_done === 1'b1) break;
      n_low++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("init_done low cycles", DW'(n_low), DW'(CLEAR_CYCLES));
    check("quiet during clear", DW'(n_bad), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mkv(1, 5,    '1,           {32{8'hA5}},      0, 0,    '0);
    vecs[1]  = mkv(0, 0,    '0,           '0,               1, 5,    {32{8'hA5}});
    vecs[2]  = mkv(1, 9,    '1,           '0,               0, 0,    '0);
    vecs[3]  = mkv(1, 9,    32'h0000_000F, '1,              0, 0,    '0);
    vecs[4]  = mkv(0, 0,    '0,           '0,               1, 9,    DW'(32'hFFFF_FFFF));
    vecs[5]  = mkv(1, 3,    '1,           {32{8'h22}},      0, 0,    '0);
`ifdef KNN_SP_RDW_FWD_EN
    vecs[6]  = mkv(1, 3,    '1,           {32{8'h11}},      1, 3,    {32{8'h11}});
`else
    vecs[6]  = mkv(1, 3,    '1,           {32{8'h11}},      1, 3,    {32{8'h22}});
`endif
    vecs[7]  = mkv(0, 0,    '0,           '0,               1, 3,    {32{8'h11}});
    vecs[8]  = mkv(1, 2047, '1,           {8{32'h1234_5678}}, 1, 0,  '0);
    vecs[9]  = mkv(0, 0,    '0,           '0,               1, 2047, {8{32'h1234_5678}});
    vecs[10] = mkv(1, 4,    32'h8000_0001, {32{8'h77}},     0, 0,    '0);
    vecs[11] = mkv(0, 0,    '0,           '0,               1, 4,    {8'h77, 240'h0, 8'h77});

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Every address reads back zero after the sweep.
    for (int a = 0; a < DEPTH; a++) cycle_op(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, '0);
    idle(LAT + 2);

    for (int i = 0; i < 12; i++) begin
      cycle_op(vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].re, vecs[i].ra,
               1'b1, vecs[i].exp);
    end
    idle(LAT + 2);

    // Back-to-back reads alternating banks.
    for (int a = 0; a < 8; a++) cycle_op(1'b1, AW'(a), '1, rand_word(), 1'b0, '0, 1'b0, '0);
    for (int a = 0; a < 8; a++) cycle_op(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, '0);
    idle(LAT + 2);

    // Random traffic in a small window plus the top of the array, to force collisions.
    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] wa, ra;
      wa = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH - 4, DEPTH - 1))
                                       : AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH - 4, DEPTH - 1))
                                       : AW'($urandom_range(0, 15));
      cycle_op(1'($urandom_range(0, 1)), wa, $urandom(), rand_word(),
               1'($urandom_range(0, 3) != 0), ra, 1'b0, '0);
    end
    idle(LAT + 2);
    check("queue drained", DW'(expq.size()), DW'(0));

    // Reset during a read burst; contents must come back zeroed.
    for (int a = 0; a < 4; a++) cycle_op(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, '0);
    do_reset();
    for (int a = 0; a < 16; a++) cycle_op(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, '0);
    for (int a = DEPTH - 4; a < DEPTH; a++) cycle_op(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, '0);
    idle(LAT + 2);
    check("final queue drained", DW'(expq.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
